// File: rtl/riscv_pipe_pkg.sv
// ============================================================================
//  Module      : riscv_pipe_pkg
//  Description : Shared types and constants for the EX->MEM pipeline stage.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_pipe_pkg;

    localparam int c_xlen       = 32;
    localparam int c_reg_addr_w = 5;

    typedef logic [1:0] state_t;
    localparam state_t c_st_empty = 2'd0;
    localparam state_t c_st_busy  = 2'd1;
    localparam state_t c_st_full  = 2'd2;

    typedef struct packed {
        logic [c_xlen-1:0]       alu_result;
        logic [c_xlen-1:0]       store_data;
        logic [c_reg_addr_w-1:0] rd;
        logic                    reg_write;
        logic                    mem_read;
        logic                    mem_write;
        logic [2:0]              funct3;
    } ex_mem_payload_t;

endpackage

`default_nettype wire

// File: rtl/pipe_skid_buf.sv
// ============================================================================
//  Module      : pipe_skid_buf
//  Description : Generic 2-entry skid buffer (EMPTY/BUSY/FULL) with sync flush.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_skid_buf
    import riscv_pipe_pkg::*;
#(
    parameter type T = logic
) (
    input  logic clk,
    input  logic reset,
    input  logic i_flush,
    input  logic i_valid,
    output logic o_ready,
    input  T     i_data,
    output logic o_valid,
    input  logic i_ready,
    output T     o_data
);

    state_t r_state;
    state_t w_state_nxt;
    T       r_main;
    T       r_skid;

    logic w_in_xfer;
    logic w_out_xfer;
    logic w_load_main_in;
    logic w_load_main_skid;
    logic w_load_skid;

    // Ready depends only on the state flop, never on i_ready.
    assign o_ready    = (r_state != c_st_full);
    assign o_valid    = (r_state != c_st_empty);
    assign o_data     = r_main;
    assign w_in_xfer  = i_valid & o_ready;
    assign w_out_xfer = o_valid & i_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_st_empty;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (i_flush) begin
            w_state_nxt = c_st_empty;
        end else begin
            case (r_state)
                c_st_empty: begin
                    if (w_in_xfer) begin
                        w_state_nxt    = c_st_busy;
                        w_load_main_in = 1'b1;
                    end
                end
                c_st_busy: begin
                    if (w_in_xfer && w_out_xfer) begin
                        w_load_main_in = 1'b1;
                    end else if (w_in_xfer) begin
                        w_state_nxt = c_st_full;
                        w_load_skid = 1'b1;
                    end else if (w_out_xfer) begin
                        w_state_nxt = c_st_empty;
                    end
                end
                c_st_full: begin
                    if (w_out_xfer) begin
                        w_state_nxt      = c_st_busy;
                        w_load_main_skid = 1'b1;
                    end
                end
                default: w_state_nxt = c_st_empty;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_main <= '0;
            r_skid <= '0;
        end else if (i_flush) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            if (w_load_main_in) begin
                r_main <= i_data;
            end else if (w_load_main_skid) begin
                r_main <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= i_data;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/ex_mem_pipe_stage.sv
// ============================================================================
//  Module      : ex_mem_pipe_stage
//  Description : EX->MEM pipeline register with skid buffer, x0 rule, control
//                gating and optional perf counters (EXMEM_PERF_CNT_EN).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_mem_pipe_stage
    import riscv_pipe_pkg::*;
#(
    parameter int XLEN       = c_xlen,
    parameter int REG_ADDR_W = c_reg_addr_w
`ifdef EXMEM_PERF_CNT_EN
    ,
    parameter int CNT_W      = 16
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  ex_valid,
    output logic                  ex_ready,
    input  logic [XLEN-1:0]       ex_alu_result,
    input  logic [XLEN-1:0]       ex_store_data,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_reg_write,
    input  logic                  ex_mem_read,
    input  logic                  ex_mem_write,
    input  logic [2:0]            ex_funct3,
    output logic                  mem_valid,
    input  logic                  mem_ready,
    output logic [XLEN-1:0]       mem_alu_result,
    output logic [XLEN-1:0]       mem_store_data,
    output logic [REG_ADDR_W-1:0] mem_rd,
    output logic                  mem_reg_write,
    output logic                  mem_mem_read,
    output logic                  mem_mem_write,
    output logic [2:0]            mem_funct3
`ifdef EXMEM_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]      perf_stall_cnt,
    output logic [CNT_W-1:0]      perf_flush_cnt
`endif
);

    ex_mem_payload_t w_in_p;
    ex_mem_payload_t w_out_p;

    // A write to x0 is architecturally a no-op, so drop the enable at entry.
    always_comb begin
        w_in_p            = '0;
        w_in_p.alu_result = ex_alu_result;
        w_in_p.store_data = ex_store_data;
        w_in_p.rd         = ex_rd;
        w_in_p.reg_write  = ex_reg_write & (ex_rd != '0);
        w_in_p.mem_read   = ex_mem_read;
        w_in_p.mem_write  = ex_mem_write;
        w_in_p.funct3     = ex_funct3;
    end

    pipe_skid_buf #(
        .T (ex_mem_payload_t)
    ) u_skid (
        .clk     (clk),
        .reset   (reset),
        .i_flush (flush),
        .i_valid (ex_valid),
        .o_ready (ex_ready),
        .i_data  (w_in_p),
        .o_valid (mem_valid),
        .i_ready (mem_ready),
        .o_data  (w_out_p)
    );

    assign mem_alu_result = w_out_p.alu_result;
    assign mem_store_data = w_out_p.store_data;
    assign mem_rd         = w_out_p.rd;
    assign mem_funct3     = w_out_p.funct3;
    assign mem_reg_write  = w_out_p.reg_write & mem_valid;
    assign mem_mem_read   = w_out_p.mem_read  & mem_valid;
    assign mem_mem_write  = w_out_p.mem_write & mem_valid;

`ifdef EXMEM_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (mem_valid && !mem_ready && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (flush && mem_valid && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign perf_stall_cnt = r_stall_cnt;
    assign perf_flush_cnt = r_flush_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ex_mem_pipe_stage.sv
// ============================================================================
//  Module      : tb_ex_mem_pipe_stage
//  Description : Scoreboard bench for ex_mem_pipe_stage (EXMEM_PERF_CNT_EN aware).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ex_mem_pipe_stage;
    import riscv_pipe_pkg::*;

    logic            clk = 1'b0;
    logic            reset;
    logic            flush;
    logic            ex_valid;
    logic            ex_ready;
    ex_mem_payload_t ex_p;
    logic            mem_valid;
    logic            mem_ready;
    logic [31:0]     mem_alu_result;
    logic [31:0]     mem_store_data;
    logic [4:0]      mem_rd;
    logic            mem_reg_write;
    logic            mem_mem_read;
    logic            mem_mem_write;
    logic [2:0]      mem_funct3;
    ex_mem_payload_t out_p;

    int n_vec = 0;
    int n_err = 0;

    ex_mem_payload_t q[$];
    ex_mem_payload_t held;
    logic            held_valid;

    always #5 clk = ~clk;

`ifdef EXMEM_PERF_CNT_EN
    logic [15:0] perf_stall_cnt, perf_flush_cnt;
    logic [1:0]  sat_stall_cnt, sat_flush_cnt;
    logic [15:0] m_stall, m_flush;
    logic [1:0]  m_sat_stall;
    logic        s_ready, s_valid, s_rw, s_mr, s_mw;
    logic [31:0] s_alu, s_sd;
    logic [4:0]  s_rd;
    logic [2:0]  s_f3;
`endif

    ex_mem_pipe_stage dut (
        .clk(clk), .reset(reset), .flush(flush),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_alu_result(ex_p.alu_result), .ex_store_data(ex_p.store_data),
        .ex_rd(ex_p.rd), .ex_reg_write(ex_p.reg_write),
        .ex_mem_read(ex_p.mem_read), .ex_mem_write(ex_p.mem_write),
        .ex_funct3(ex_p.funct3),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_alu_result(mem_alu_result), .mem_store_data(mem_store_data),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
        .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
        .mem_funct3(mem_funct3)
`ifdef EXMEM_PERF_CNT_EN
        ,
        .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
    );

`ifdef EXMEM_PERF_CNT_EN
    ex_mem_pipe_stage #(.CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .flush(flush),
        .ex_valid(ex_valid), .ex_ready(s_ready),
        .ex_alu_result(ex_p.alu_result), .ex_store_data(ex_p.store_data),
        .ex_rd(ex_p.rd), .ex_reg_write(ex_p.reg_write),
        .ex_mem_read(ex_p.mem_read), .ex_mem_write(ex_p.mem_write),
        .ex_funct3(ex_p.funct3),
        .mem_valid(s_valid), .mem_ready(mem_ready),
        .mem_alu_result(s_alu), .mem_store_data(s_sd),
        .mem_rd(s_rd), .mem_reg_write(s_rw),
        .mem_mem_read(s_mr), .mem_mem_write(s_mw),
        .mem_funct3(s_f3),
        .perf_stall_cnt(sat_stall_cnt), .perf_flush_cnt(sat_flush_cnt)
    );
`endif

    assign out_p = {mem_alu_result, mem_store_data, mem_rd, mem_reg_write,
                    mem_mem_read, mem_mem_write, mem_funct3};

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic ex_mem_payload_t exp_of(input ex_mem_payload_t p);
        ex_mem_payload_t r;
        r           = p;
        r.reg_write = p.reg_write && (p.rd != 5'd0);
        return r;
    endfunction

    task automatic model_reset();
        q.delete();
        held_valid = 1'b0;
`ifdef EXMEM_PERF_CNT_EN
        m_stall     = '0;
        m_flush     = '0;
        m_sat_stall = '0;
`endif
    endtask

    // One clock: check at the falling edge, advance the model, return after the rising edge.
    task automatic tick();
        logic exp_ready;
        @(negedge clk);
        exp_ready = (q.size() < 2);
        chk("ex_ready", 128'(ex_ready), 128'(exp_ready));
        chk("mem_valid", 128'(mem_valid), 128'(q.size() != 0));
        if (q.size() != 0)
            chk("head_payload", 128'(out_p), 128'(q[0]));
        else
            chk("ctrl_gate", 128'({mem_reg_write, mem_mem_read, mem_mem_write}), 128'(0));
        if (held_valid && q.size() != 0)
            chk("stall_hold", 128'(out_p), 128'(held));
`ifdef EXMEM_PERF_CNT_EN
        chk("perf_stall", 128'(perf_stall_cnt), 128'(m_stall));
        chk("perf_flush", 128'(perf_flush_cnt), 128'(m_flush));
        chk("perf_stall_sat", 128'(sat_stall_cnt), 128'(m_sat_stall));
        if (q.size() != 0 && !mem_ready) begin
            if (m_stall != 16'hFFFF) m_stall++;
            if (m_sat_stall != 2'd3) m_sat_stall++;
        end
        if (flush && q.size() != 0 && m_flush != 16'hFFFF) m_flush++;
`endif
        held_valid = (q.size() != 0) && !mem_ready && !flush;
        held       = out_p;
        if (flush) begin
            q.delete();
        end else begin
            if (q.size() != 0 && mem_ready) void'(q.pop_front());
            if (ex_valid && exp_ready) q.push_back(exp_of(ex_p));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic v, input logic [31:0] alu, input logic [4:0] rd,
                       input logic rw, input logic mr, input logic mw,
                       input logic rdy, input logic fl);
        ex_valid          = v;
        ex_p.alu_result   = alu;
        ex_p.store_data   = $urandom;
        ex_p.rd           = rd;
        ex_p.reg_write    = rw;
        ex_p.mem_read     = mr;
        ex_p.mem_write    = mw;
        ex_p.funct3       = 3'($urandom_range(7));
        mem_ready         = rdy;
        flush             = fl;
        tick();
    endtask

    task automatic idle(input logic rdy);
        drv(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, rdy, 1'b0);
    endtask

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        ex_valid  = 1'b0;
        ex_p      = '0;
        mem_ready = 1'b0;
        model_reset();
        #2;
        chk("reset_outputs", 128'({mem_valid, out_p}), 128'(0));
        #10;
        reset = 1'b0;
        idle(1'b1);

        // Streaming at full rate.
        for (int i = 0; i < 4; i++)
            drv(1'b1, 32'h10 + 32'(i), 5'(i + 1), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);

        // Stall on B's cycle, D offered while full, then drain.
        drv(1'b1, 32'hA, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        drv(1'b1, 32'hB, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drv(1'b1, 32'hD, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drv(1'b1, 32'hD, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);

        // Flush while FULL with C offered; then flush while BUSY; then while empty.
        drv(1'b1, 32'hE, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drv(1'b1, 32'hF, 5'd7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        drv(1'b1, 32'hC, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(1'b1);
        drv(1'b1, 32'h20, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drv(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        drv(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(1'b1);

        // Writes to x0 must arrive with reg_write cleared.
        drv(1'b1, 32'h30, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        drv(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("x0_reg_write", 128'({mem_valid, mem_reg_write}), 128'(2'b10));
        idle(1'b1);

        // Async reset while a store is held.
        drv(1'b1, 32'h40, 5'd10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        ex_valid = 1'b0;
        chk("store_held", 128'({mem_valid, mem_mem_write}), 128'(2'b11));
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset", 128'({mem_valid, out_p}), 128'(0));
        model_reset();
        #8;
        reset = 1'b0;
        for (int i = 0; i < 3; i++)
            drv(1'b1, 32'h50 + 32'(i), 5'(i + 11), 1'b1, 1'b0, 1'b0, (i != 1), 1'b0);
        for (int i = 0; i < 20 && q.size() != 0; i++)
            idle(1'b1);
        chk("drained", 128'(q.size()), 128'(0));
        idle(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
